// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide sequencer: op codes,
// FSM state encoding and iteration counter width.
package mdu_pkg;

    localparam logic [1:0] MDU_MULTU = 2'b00;
    localparam logic [1:0] MDU_MULT  = 2'b01;
    localparam logic [1:0] MDU_DIVU  = 2'b10;
    localparam logic [1:0] MDU_DIV   = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PREP = 3'd1;
    localparam logic [2:0] ST_ITER = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam int MDU_CNT_W = 5;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/mdu_addsub.sv
// Single add/subtract step shared by multiply (add) and restoring divide (trial subtract).
// sub=0: x+y; sub=1: x+~y+1, where cout=1 means no borrow.
module mdu_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] full;

    assign full = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{W{1'b0}}, sub};
    assign sum  = full[W-1:0];
    assign cout = full[W];

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU controller writing HI/LO after WIDTH shift steps.
// Optional MDU_EARLY_OUT_EN: zero-operand multiplies and divide-by-zero skip the iterations.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [2:0]           state;
    logic [MDU_CNT_W-1:0] cnt;
    logic [1:0]           op_q;
    logic [WIDTH-1:0]     acc;     // product upper half / partial remainder
    logic [WIDTH-1:0]     sr;      // multiplier -> product lower / dividend -> quotient
    logic [WIDTH-1:0]     opnd;    // multiplicand / divisor magnitude
    logic                 neg_res;
    logic                 neg_rem;
    logic                 dz_pend;

    logic                 is_div;
    logic                 is_sgn;
    logic                 accept;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [WIDTH:0]       add_x;
    logic [WIDTH:0]       add_y;
    logic [WIDTH:0]       add_sum;
    logic                 add_cout;
    logic [2*WIDTH-1:0]   prod_neg;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    // Handshake: an op is taken on a rising edge where start=1, busy=0 and flush=0;
    // busy stays high until the op completes or is flushed, done pulses once on completion.
    assign accept = start && !flush && (state == ST_IDLE || state == ST_DONE);
    assign busy   = (state == ST_PREP) || (state == ST_ITER) || (state == ST_FIX);
    assign done   = (state == ST_DONE);
    assign is_div = op_is_div(op_q);
    assign is_sgn = op_is_signed(op_q);

    // In PREP, sr still holds raw a and opnd raw b.
    assign a_abs = (is_sgn && sr[WIDTH-1])   ? -sr   : sr;
    assign b_abs = (is_sgn && opnd[WIDTH-1]) ? -opnd : opnd;

    assign add_x = is_div ? {acc, sr[WIDTH-1]} : {1'b0, acc};
    assign add_y = (is_div || sr[0]) ? {1'b0, opnd} : '0;

    mdu_addsub #(.W(WIDTH + 1)) u_addsub (
        .x    (add_x),
        .y    (add_y),
        .sub  (is_div),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign prod_neg = -{acc, sr};
    assign fix_hi   = is_div ? (neg_rem ? -acc : acc) : (neg_res ? prod_neg[2*WIDTH-1:WIDTH] : acc);
    assign fix_lo   = is_div ? (neg_res ? -sr  : sr)  : (neg_res ? prod_neg[WIDTH-1:0]       : sr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            op_q    <= MDU_MULTU;
            acc     <= '0;
            sr      <= '0;
            opnd    <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            dz_pend <= 1'b0;
            dz      <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        op_q  <= op;
                        sr    <= a;
                        opnd  <= b;
                        dz    <= 1'b0;
                        state <= ST_PREP;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_PREP: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        neg_res <= is_sgn && (sr[WIDTH-1] ^ opnd[WIDTH-1]);
                        neg_rem <= is_sgn && sr[WIDTH-1];
                        dz_pend <= is_div && (opnd == '0);
                        acc     <= '0;
                        cnt     <= '0;
                        sr      <= is_div ? a_abs : b_abs;
                        opnd    <= is_div ? b_abs : a_abs;
                        state   <= ST_ITER;
`ifdef MDU_EARLY_OUT_EN
                        // Same results the full run would produce for these operands.
                        if (is_div ? (opnd == '0) : (sr == '0 || opnd == '0)) begin
                            hi    <= is_div ? sr : '0;
                            lo    <= is_div ? ((is_sgn && sr[WIDTH-1]) ? WIDTH'(1) : '1) : '0;
                            dz    <= is_div;
                            state <= ST_DONE;
                        end
`endif
                    end
                end
                ST_ITER: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        if (is_div) begin
                            acc <= add_cout ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0];
                            sr  <= {sr[WIDTH-2:0], add_cout};
                        end else begin
                            acc <= add_sum[WIDTH:1];
                            sr  <= {add_sum[0], sr[WIDTH-1:1]};
                        end
                        cnt <= cnt + MDU_CNT_W'(1);
                        if (cnt == MDU_CNT_W'(WIDTH - 1)) state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (flush) begin
                        state <= ST_IDLE;
                    end else begin
                        hi    <= fix_hi;
                        lo    <= fix_lo;
                        dz    <= dz_pend;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
